// File: rtl/segment_number_reader.sv
// Seven-segment frame reader: decodes one digit per beat (LSD first) and rebuilds the binary number.
// Optional: define SEG_READER_ERROR_EN to abort frames on invalid segment patterns and pulse error.
module segment_number_reader #(
  parameter int NUMBER_WIDTH = 16,
  parameter int MAX_DIGITS   = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             seg_valid,
  input  logic                             top_left,
  input  logic                             top,
  input  logic                             top_right,
  input  logic                             bottom_right,
  input  logic                             bottom,
  input  logic                             bottom_left,
  input  logic                             middle,
  output logic [NUMBER_WIDTH-1:0]          number,
  output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count,
  output logic                             done,
  output logic                             busy,
  output logic                             error
);

  localparam int CW = $clog2(MAX_DIGITS+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]              state;
  logic [NUMBER_WIDTH-1:0] acc;
  logic [NUMBER_WIDTH-1:0] place;
  logic [CW-1:0]           count;

  logic [6:0]              pattern;
  logic [3:0]              dig;
  logic                    is_empty;
  logic                    is_bad;
  logic [NUMBER_WIDTH-1:0] addend;
  logic [NUMBER_WIDTH-1:0] acc_next;
  logic [NUMBER_WIDTH-1:0] place_next;
  logic [CW-1:0]           count_next;
  logic                    last_digit;

  assign pattern = {top_left, top, top_right, bottom_right, bottom, bottom_left, middle};

  // Unrecognised patterns decode as digit 0 and raise is_bad.
  always_comb begin
    dig      = 4'd0;
    is_empty = 1'b0;
    is_bad   = 1'b0;
    case (pattern)
      7'h7E:   dig = 4'd0;
      7'h18:   dig = 4'd1;
      7'h37:   dig = 4'd2;
      7'h3D:   dig = 4'd3;
      7'h59:   dig = 4'd4;
      7'h6D:   dig = 4'd5;
      7'h6F:   dig = 4'd6;
      7'h38:   dig = 4'd7;
      7'h7F:   dig = 4'd8;
      7'h7D:   dig = 4'd9;
      7'h00:   is_empty = 1'b1;
      default: is_bad = 1'b1;
    endcase
  end

  // dig*place and place*10 as shift-add, wrapping at NUMBER_WIDTH.
  always_comb begin
    addend = '0;
    if (dig[0]) addend = addend + place;
    if (dig[1]) addend = addend + (place << 1);
    if (dig[2]) addend = addend + (place << 2);
    if (dig[3]) addend = addend + (place << 3);
    acc_next   = acc + addend;
    place_next = (place << 3) + (place << 1);
    count_next = count + CW'(1);
    last_digit = (count_next == CW'(MAX_DIGITS));
  end

  assign done = (state == DONE);
  assign busy = (state == ACCUM);

`ifdef SEG_READER_ERROR_EN
  logic error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
  logic unused_bad;
  assign unused_bad = is_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      place       <= NUMBER_WIDTH'(1);
      count       <= '0;
      number      <= '0;
      digit_count <= '0;
`ifdef SEG_READER_ERROR_EN
      error_q     <= 1'b0;
`endif
    end else begin
`ifdef SEG_READER_ERROR_EN
      error_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            place <= NUMBER_WIDTH'(1);
            count <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (start) begin
            acc   <= '0;
            place <= NUMBER_WIDTH'(1);
            count <= '0;
          end else if (seg_valid) begin
            if (is_empty) begin
              number      <= acc;
              digit_count <= count;
              state       <= DONE;
            end
`ifdef SEG_READER_ERROR_EN
            else if (is_bad) begin
              error_q <= 1'b1;
              state   <= IDLE;
            end
`endif
            else begin
              acc   <= acc_next;
              place <= place_next;
              count <= count_next;
              if (last_digit) begin
                number      <= acc_next;
                digit_count <= count_next;
                state       <= DONE;
              end
            end
          end
        end
        DONE: begin
          if (start) begin
            acc   <= '0;
            place <= NUMBER_WIDTH'(1);
            count <= '0;
            state <= ACCUM;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segment_number_reader.sv
// Scoreboard bench for segment_number_reader: directed frames plus random beats against a digit-list model.
module tb_segment_number_reader;

  localparam int W   = 16;
  localparam int MAX = 5;
  localparam int CW  = $clog2(MAX+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, seg_valid = 1'b0;
  logic top_left = 1'b0, top = 1'b0, top_right = 1'b0, bottom_right = 1'b0;
  logic bottom = 1'b0, bottom_left = 1'b0, middle = 1'b0;
  logic [W-1:0]  number;
  logic [CW-1:0] digit_count;
  logic done, busy, error;

  always #5 clk = ~clk;

  segment_number_reader #(.NUMBER_WIDTH(W), .MAX_DIGITS(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seg_valid(seg_valid),
    .top_left(top_left), .top(top), .top_right(top_right), .bottom_right(bottom_right),
    .bottom(bottom), .bottom_left(bottom_left), .middle(middle),
    .number(number), .digit_count(digit_count), .done(done), .busy(busy), .error(error)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] pat [10] = '{7'h7E, 7'h18, 7'h37, 7'h3D, 7'h59, 7'h6D, 7'h6F, 7'h38, 7'h7F, 7'h7D};

  // Reference model: an open flag plus the list of digits received so far.
  bit            m_open = 0;
  int            digs[$];
  logic [W-1:0]  exp_num = '0;
  logic [CW-1:0] exp_cnt = '0;
  bit            exp_err = 0;
  logic [CW+W-1:0] sb[$];

  function automatic int lookup(input logic [6:0] p);
    for (int k = 0; k < 10; k++) if (pat[k] == p) return k;
    return -1;
  endfunction

  task automatic model_finish();
    longint acc = 0, pw = 1;
    foreach (digs[i]) begin
      acc += longint'(digs[i]) * pw;
      pw  *= 10;
    end
    exp_num = W'(acc % (longint'(1) << W));
    exp_cnt = CW'(digs.size());
    sb.push_back({exp_cnt, exp_num});
    m_open = 0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [6:0] p);
    int d;
    exp_err = 0;
    if (!m_open) begin
      if (s) begin m_open = 1; digs.delete(); end
    end else if (s) begin
      digs.delete();
    end else if (v) begin
      d = lookup(p);
      if (p == 7'h00) model_finish();
      else begin
`ifdef SEG_READER_ERROR_EN
        if (d < 0) begin exp_err = 1; m_open = 0; end
        else begin
          digs.push_back(d);
          if (digs.size() == MAX) model_finish();
        end
`else
        digs.push_back(d < 0 ? 0 : d);
        if (digs.size() == MAX) model_finish();
`endif
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [6:0] p);
    start = s; seg_valid = v;
    {top_left, top, top_right, bottom_right, bottom, bottom_left, middle} = p;
    model_step(s, v, p);
    @(posedge clk); #1;
    start = 0; seg_valid = 0;
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_open));
    check("error", 32'(error), 32'(exp_err));
    check("number_hold", 32'(number), 32'(exp_num));
    check("count_hold", 32'(digit_count), 32'(exp_cnt));
  endtask

  task automatic beat(input logic [6:0] p); step(1'b0, 1'b1, p); endtask
  task automatic go(); step(1'b1, 1'b0, 7'h00); endtask
  task automatic idle(); step(1'b0, 1'b0, 7'h00); endtask

  task automatic check_reset_outputs();
    check("rst_number", 32'(number), 0);
    check("rst_count", 32'(digit_count), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_error", 32'(error), 0);
  endtask

  // Monitor: every done pulse must match the oldest expected frame result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got number=%0d count=%0d, none expected", number, digit_count);
      end else begin
        logic [CW+W-1:0] e;
        e = sb.pop_front();
        if ({digit_count, number} !== e) begin
          errors++;
          $display("FAIL done_value: got number=%0d count=%0d expected number=%0d count=%0d",
                   number, digit_count, e[W-1:0], e[CW+W-1:W]);
        end
      end
    end
  end

  initial begin
    logic [6:0] p;
    int r;
    #3;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1;
    @(negedge clk);

    // 135: 5,3,1 then empty
    go(); beat(7'h6D); beat(7'h3D); beat(7'h18); beat(7'h00);
    check("t1_done", 32'(done), 1);
    idle();
    check("t1_done_one_cycle", 32'(done), 0);
    check("t1_number", 32'(number), 135);
    check("t1_count", 32'(digit_count), 3);

    // empty first beat
    go(); beat(7'h00); idle();
    check("t2_number", 32'(number), 0);
    check("t2_count", 32'(digit_count), 0);

    // auto-terminate at MAX digits, 65535
    go(); beat(7'h6D); beat(7'h3D); beat(7'h6D); beat(7'h6D); beat(7'h6F);
    check("t3_done", 32'(done), 1);
    idle();
    check("t3_number", 32'(number), 65535);
    check("t3_count", 32'(digit_count), 5);

    // restart mid-frame, start in same cycle as a beat, start during DONE
    go(); beat(7'h38); beat(7'h38); go(); beat(7'h37); beat(7'h00);
    check("t4_number", 32'(number), 2);
    check("t4_count", 32'(digit_count), 1);
    go(); step(1'b1, 1'b1, 7'h18); beat(7'h3D); beat(7'h00); go(); beat(7'h00); idle();

    // invalid pattern 01
    go(); beat(7'h18); beat(7'h01); beat(7'h00); idle();

    // beats while idle are ignored
    beat(7'h18); beat(7'h00); idle();

    // reset mid-frame
    go(); beat(7'h7F); beat(7'h7F);
    #2 rst_n = 0;
    m_open = 0; digs.delete(); exp_num = '0; exp_cnt = '0;
    #1 check_reset_outputs();
    @(negedge clk); rst_n = 1;
    idle(); idle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4 || (!m_open && r < 40)) begin
        go();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 70) beat(pat[$urandom_range(0, 9)]);
        else if (r < 80) beat(7'h00);
        else if (r < 88) begin
          do p = 7'($urandom_range(1, 127)); while (lookup(p) >= 0);
          beat(p);
        end else idle();
      end
    end

    repeat (3) idle();
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
